// File: rtl/fpga_ram_nrmw_lvt.sv
// Multi-read, multi-write LUTRAM register file. Each write port owns one bank per read port,
// and a live-value table (LVT) records which write port last wrote each entry.
//
// state | meaning
// IDLE  | normal operation; write ports update banks and LVT
// CLEAR | walks every address writing RESET_VAL into bank group 0; busy_o high
module fpga_ram_nrmw_lvt #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 32,
    parameter int               NR        = 7,
    parameter int               NW        = 2,
    parameter int               BYPASS    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 busy_o,
    input  logic [NR-1:0][$clog2(DEPTH)-1:0]     raddr_i,
    output logic [NR-1:0][WIDTH-1:0]             rdata_o,
    input  logic [NW-1:0][$clog2(DEPTH)-1:0]     waddr_i,
    input  logic [NW-1:0][WIDTH-1:0]             wdata_i,
    input  logic [NW-1:0]                        we_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [LW-1:0]   lvt [DEPTH];
    logic [WIDTH-1:0] mem [NW][NR][DEPTH];
    logic            wr_ok;
    logic            clr_ok;

    assign wr_ok  = !rst && !busy_o;
    assign clr_ok = !rst && (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy_o  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Ascending port order means the highest enabled port wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
        end else if (wr_ok) begin
            for (int w = 0; w < NW; w++)
                if (we_i[w]) lvt[waddr_i[w]] <= LW'(w);
        end
    end

    // Banks carry no reset; the clear walk only needs group 0 since the LVT points there.
    always_ff @(posedge clk) begin
        if (clr_ok) begin
            for (int r = 0; r < NR; r++) mem[0][r][clr_cnt] <= RESET_VAL;
        end else if (wr_ok) begin
            for (int w = 0; w < NW; w++)
                if (we_i[w])
                    for (int r = 0; r < NR; r++) mem[w][r][waddr_i[w]] <= wdata_i[w];
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NR; r++) begin
            rdata_o[r] = mem[0][r][raddr_i[r]];
            for (int w = 1; w < NW; w++)
                if (lvt[raddr_i[r]] == LW'(w)) rdata_o[r] = mem[w][r][raddr_i[r]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NW; w++)
                    if (we_i[w] && (waddr_i[w] == raddr_i[r])) rdata_o[r] = wdata_i[w];
            end
            if (busy_o) rdata_o[r] = RESET_VAL;
        end
    end
endmodule

// File: tb/tb_fpga_ram_nrmw_lvt.sv
// Directed checks on 2-write/7-read builds with and without bypass, then a scoreboard
// run on a 3-write/7-read, 64-deep bypass build.
module tb_fpga_ram_nrmw_lvt;
    localparam logic [31:0] RV0 = 32'hDEAD_BEEF;
    localparam logic [31:0] RV2 = 32'h0BAD_F00D;

    logic clk;
    logic rst;
    logic [6:0][4:0]  raddr;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic             busy0, busy1;
    logic [6:0][31:0] rdata0, rdata1;

    logic             r_rst;
    logic [6:0][5:0]  r_raddr;
    logic [2:0][5:0]  r_waddr;
    logic [2:0][31:0] r_wdata;
    logic [2:0]       r_we;
    logic             r_busy;
    logic [6:0][31:0] r_rdata;

    logic [31:0] model [64];

    int checks = 0;
    int errors = 0;

    fpga_ram_nrmw_lvt #(.WIDTH(32), .DEPTH(32), .NR(7), .NW(2), .BYPASS(0), .RESET_VAL(RV0)) dut0 (
        .clk(clk), .rst(rst), .busy_o(busy0), .raddr_i(raddr), .rdata_o(rdata0),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

    fpga_ram_nrmw_lvt #(.WIDTH(32), .DEPTH(32), .NR(7), .NW(2), .BYPASS(1), .RESET_VAL(RV0)) dut1 (
        .clk(clk), .rst(rst), .busy_o(busy1), .raddr_i(raddr), .rdata_o(rdata1),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we));

    fpga_ram_nrmw_lvt #(.WIDTH(32), .DEPTH(64), .NR(7), .NW(3), .BYPASS(1), .RESET_VAL(RV2)) dut2 (
        .clk(clk), .rst(r_rst), .busy_o(r_busy), .raddr_i(r_raddr), .rdata_o(r_rdata),
        .waddr_i(r_waddr), .wdata_i(r_wdata), .we_i(r_we));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int a, input logic [31:0] exp);
        for (int r = 0; r < 7; r++) raddr[r] = 5'(a);
        #1;
        for (int r = 0; r < 7; r++) begin
            check({tag, "_nb"}, rdata0[r], exp);
            check({tag, "_by"}, rdata1[r], exp);
        end
    endtask

    // Counts cycles until busy drops; optionally hammers the write ports at addr 7 meanwhile.
    task automatic wait_clear(input bit poke, output int n);
        n = 0;
        while (busy0 && n < 100) begin
            if (poke) begin
                we       = 2'b11;
                waddr[0] = 5'(n);
                waddr[1] = 5'd7;
                wdata[0] = 32'h5000_0000 + 32'(n);
                wdata[1] = 32'h6000_0000 + 32'(n);
                raddr[0] = 5'd7;
                raddr[3] = 5'(n);
                #1;
                check("clr_rd_nb", rdata0[0], RV0);
                check("clr_rd_by", rdata1[0], RV0);
                check("clr_rd3_by", rdata1[3], RV0);
            end
            tick();
            n++;
        end
        we = 2'b00;
    endtask

    int n;
    logic [31:0] exp;

    initial begin
        rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
        r_rst = 1'b1; r_raddr = '0; r_waddr = '0; r_wdata = '0; r_we = '0;

        // Reset state and clear sequence
        repeat (3) tick();
        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd1);
        check_all("rst_rd", 9, RV0);
        rst = 1'b0;
        wait_clear(1'b1, n);
        check("clr_len", 32'(n), 32'd32);
        check("clr_busy1", 32'(busy1), 32'd0);
        for (int a = 0; a < 32; a++) check_all("post_clr", a, RV0);

        // Basic write/read
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h1234_5678;
        tick(); we = 2'b00;
        check_all("wr5", 5, 32'h1234_5678);
        check_all("wr4", 4, RV0);
        check_all("wr6", 6, RV0);

        // LVT switching between ports
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h0000_AAAA;
        tick(); we = 2'b00;
        check_all("lvt_a", 9, 32'h0000_AAAA);
        we = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'h0000_BBBB;
        tick(); we = 2'b00;
        check_all("lvt_b", 9, 32'h0000_BBBB);
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h0000_CCCC;
        tick(); we = 2'b00;
        check_all("lvt_c", 9, 32'h0000_CCCC);

        // Same-cycle collision: port 1 wins
        we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3; wdata[0] = 32'h11; wdata[1] = 32'h22;
        tick(); we = 2'b00;
        check_all("coll", 3, 32'h22);
        tick();
        check_all("coll2", 3, 32'h22);

        // Bypass: read port 2 sees the write in the same cycle only on the bypass build
        raddr[2] = 5'd12; we = 2'b10; waddr[1] = 5'd12; wdata[1] = 32'h77;
        #1;
        check("byp_same_nb", rdata0[2], RV0);
        check("byp_same_by", rdata1[2], 32'h77);
        tick(); we = 2'b00;
        check_all("byp_next", 12, 32'h77);

        // Reset in the middle of the clear walk
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (10) tick();
        check("midclr_busy", 32'(busy0), 32'd1);
        rst = 1'b1; tick();
        check("midclr_rst_busy", 32'(busy0), 32'd1);
        rst = 1'b0;
        wait_clear(1'b0, n);
        check("midclr_len", 32'(n), 32'd32);

        // Reset mid-run restores every entry
        we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'h55;
        tick(); we = 2'b00;
        check_all("run_a0", 0, 32'h55);
        we = 2'b10; waddr[1] = 5'd3; wdata[1] = 32'h99;
        tick(); we = 2'b00;
        check_all("run_a3", 3, 32'h99);
        rst = 1'b1; tick(); rst = 1'b0;
        wait_clear(1'b0, n);
        check("run_len", 32'(n), 32'd32);
        check_all("run_rst_a0", 0, RV0);
        check_all("run_rst_a3", 3, RV0);
        check_all("run_rst_a9", 9, RV0);

        // Scoreboard run on the 3-write, 64-deep build
        repeat (2) tick();
        r_rst = 1'b0;
        n = 0;
        while (r_busy && n < 200) begin
            for (int w = 0; w < 3; w++) begin
                r_we[w]    = 1'($urandom_range(0, 1));
                r_waddr[w] = 6'($urandom_range(0, 63));
                r_wdata[w] = $urandom;
            end
            for (int r = 0; r < 7; r++) r_raddr[r] = r_waddr[r % 3];
            #1;
            for (int r = 0; r < 7; r++) check("rnd_clr", r_rdata[r], RV2);
            tick();
            n++;
        end
        check("rnd_clr_len", 32'(n), 32'd64);
        for (int a = 0; a < 64; a++) model[a] = RV2;
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < 3; w++) begin
                r_we[w]    = 1'($urandom_range(0, 1));
                r_waddr[w] = (c % 2 == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
                r_wdata[w] = $urandom;
            end
            for (int r = 0; r < 7; r++)
                r_raddr[r] = ($urandom_range(0, 1) == 1) ? r_waddr[$urandom_range(0, 2)]
                                                         : 6'($urandom_range(0, 63));
            #1;
            for (int r = 0; r < 7; r++) begin
                exp = model[r_raddr[r]];
                for (int w = 0; w < 3; w++)
                    if (r_we[w] && r_waddr[w] == r_raddr[r]) exp = r_wdata[w];
                check("rnd_rd", r_rdata[r], exp);
            end
            for (int w = 0; w < 3; w++)
                if (r_we[w]) model[r_waddr[w]] = r_wdata[w];
            tick();
        end
        r_we = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
